// File: rtl/ram_burst_reader.sv
// Burst read initiator for a synchronous-read RAM port: issues back-to-back
// reads, captures returned words into a 2-entry buffer and streams them out
// on a valid/ready interface with full backpressure.
module ram_burst_reader #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH:0]   req_len,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   issue_left;
    logic [LEN_WIDTH-1:0]   beats_left;
    logic                   inflight;
    logic [1:0]             count;
    logic [DATA_WIDTH-1:0]  spill;

    logic                   pop_c;
    logic                   issue_c;
    logic                   accept_c;
    logic [2:0]             occ_c;
    logic [1:0]             count_n_c;
    logic [LEN_WIDTH-1:0]   beats_left_n_c;

    // Issue gating: a read may go out only if its word is guaranteed a buffer slot.
    always_comb begin
        pop_c          = out_valid & out_ready;
        occ_c          = 3'(count) + 3'(inflight) - 3'(pop_c);
        issue_c        = (state == READ) && (issue_left != '0) && (occ_c <= 3'd1);
        accept_c       = (state == IDLE) && req_valid && (req_len != '0);
        count_n_c      = count + 2'(inflight) - 2'(pop_c);
        beats_left_n_c = accept_c ? req_len : (beats_left - LEN_WIDTH'(pop_c));
    end

    // Control FSM: request acceptance, read address generation, burst completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_addr   <= '0;
            issue_left <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        mem_addr   <= req_addr;
                        issue_left <= req_len;
                        state      <= READ;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                READ: begin
                    if (issue_c) begin
                        mem_addr   <= mem_addr + ADDR_WIDTH'(1);
                        issue_left <= issue_left - LEN_WIDTH'(1);
                        if (issue_left == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop_c && out_last) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Return path: capture read data one cycle after issue into a 2-entry FIFO whose head is out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= 1'b0;
            count      <= 2'd0;
            beats_left <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            spill      <= '0;
        end else begin
            inflight   <= issue_c;
            count      <= count_n_c;
            beats_left <= beats_left_n_c;
            out_valid  <= (count_n_c != 2'd0);
            out_last   <= (count_n_c != 2'd0) && (beats_left_n_c == LEN_WIDTH'(1));
            if (inflight) begin
                if (pop_c) begin
                    if (count == 2'd2) begin
                        out_data <= spill;
                        spill    <= mem_data;
                    end else begin
                        out_data <= mem_data;
                    end
                end else if (count == 2'd0) begin
                    out_data <= mem_data;
                end else begin
                    spill <= mem_data;
                end
            end else if (pop_c) begin
                out_data <= spill;
            end
        end
    end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side initiator for one port of the team's synchronous-read RAM. That RAM registers the address on each clock edge and presents the data from that address in the following cycle.
- Accepts a burst request (start address and length) and drives the RAM address so reads are issued back to back.
- Captures the returned words into a 2-entry output buffer and streams them out on a valid/ready interface with full backpressure.
- One read per cycle is sustained when the consumer is always ready.

Parameters:
ADDR_WIDTH, 6, RAM address width; address wraps modulo 2^ADDR_WIDTH.
DATA_WIDTH, 14, RAM word width.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  burst request valid.
req_ready  out  1  block can accept a request; high only in IDLE.
req_addr  in  ADDR_WIDTH  first word address.
req_len  in  ADDR_WIDTH+1  number of words, 0..2^(ADDR_WIDTH+1)-1.
mem_addr  out  ADDR_WIDTH  to RAM port address; RAM write enable is tied low externally.
mem_data  in  DATA_WIDTH  RAM port data_out, valid one cycle after mem_addr is sampled.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer accepts the beat.
out_data  out  DATA_WIDTH  read word, head of the buffer.
out_last  out  1  high with the final beat of a burst.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - State becomes IDLE; the buffer is emptied; in-flight reads are discarded.
  - Outputs after reset: out_valid=0, out_last=0, out_data=0, mem_addr=0, busy=0, req_ready=1.
  - Reset mid-burst aborts the burst; no further beats are produced.
- States:
  - IDLE: req_ready=1. On req_valid:
    - req_len=0: stay IDLE, no beats.
    - otherwise: load addr_cnt=req_addr and issue_left=req_len, set beats_left=req_len, go to READ.
  - READ: issue reads. When issue_left reaches 0, go to DRAIN.
  - DRAIN: wait until the final beat is accepted (out_valid & out_ready & out_last), then go to IDLE. A new request can be accepted in the following cycle.
- Issue rule:
  - mem_addr = addr_cnt, a registered counter.
  - issue = (state==READ) & (issue_left!=0) & (count + inflight - pop <= 1).
    - count = buffer occupancy, 0..2.
    - inflight = a read was issued in the previous cycle.
    - pop = out_valid & out_ready.
  - On issue: addr_cnt increments, wrapping 2^ADDR_WIDTH-1 -> 0, and issue_left decrements.
  - This rule guarantees the buffer never overflows. With out_ready held high it allows one issue per cycle.
- Return path:
  - A read issued in cycle c is captured from mem_data at the end of cycle c+1. mem_data is ignored when inflight=0.
  - The buffer is a 2-entry FIFO. out_data is the head word (registered). Push and pop in the same cycle are allowed.
- Latency:
  - Request accepted at edge E0; first issue in the cycle after E0.
  - First out_valid is high 2 cycles after E0's cycle + 1, i.e. visible after edge E0+2.
  - With out_ready=1, beats follow on consecutive cycles.
- out_last is high on the beat where beats_left==1; beats_left decrements on each pop.
- Backpressure:
  - out_valid, out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - Issue stalls per the issue rule. No word is lost or duplicated.
- If req_len exceeds 2^ADDR_WIDTH, addresses wrap and the same words are re-read in order.
- req_valid while busy is ignored; req_ready=0.

Test Plan:
- RAM preloaded with mem[i]=i+100; req addr=4, len=4, out_ready=1 -> beats 104,105,106,107 on 4 consecutive cycles, first out_valid 2 cycles after the acceptance cycle, out_last only on 107, busy falls after the last beat.
- req addr=62, len=4 -> beats 162,163,100,101; mem_addr sequence 62,63,0,1.
- req addr=0, len=8, out_ready toggles 1,0,0,1,0,1,... -> all 8 words delivered in order, no drops or duplicates, out_data stable during stalls, count never exceeds 2.
- req_len=0 -> no out_valid, req_ready remains 1, busy stays 0.
- rst asserted for one cycle after the 2nd beat of a len=10 burst -> the next cycle shows out_valid=0, busy=0, req_ready=1; a new len=2 request at addr=20 yields exactly 120,121.
- req_valid held high while busy with different addr/len -> ignored; the new request is accepted only in the cycle after the final beat.
